// File: rtl/game_table_writer_if.sv
// Tile-update command channel into game_table_writer (valid/ready, no payload buffering).
// Latency: none, this is a signal bundle only.
// Backpressure: a transfer happens on the clock edge where cmd_valid && cmd_ready.
//
// Signals:
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  writer idle and able to take a command
//   cmd_op     2   0=PUT, 1=HLINE, 2=CLEAR, 3=reserved
//   cmd_x      6   start column
//   cmd_y      5   row
//   cmd_len    6   HLINE length in tiles
//   cmd_tile   4   tile/bitmap index to write
interface game_table_writer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [5:0] cmd_x;
  logic [4:0] cmd_y;
  logic [5:0] cmd_len;
  logic [3:0] cmd_tile;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_len, cmd_tile,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_len, cmd_tile,
    output cmd_ready
  );
endinterface

// File: rtl/game_table_writer.sv
// Write-port owner of the 30x40x4-bit game table RAM: turns PUT/HLINE/CLEAR commands into RAM writes.
// Latency: first TabWe 2 edges after acceptance when already in blanking, then 1 write/cycle; cmd_ready returns 1 cycle after the last write.
// Backpressure: cmd_ready only while idle; writes are gated to vertical blanking and pause/resume across frames.
//
// Ports:
//   px_clk, rst_n        pixel clock, asynchronous active-low reset
//   RGBStr_i[25:0]       pixel stream; only the `YC line counter field is looked at
//   cmd (slave modport)  command channel, see game_table_writer_if
//   TabWAdd/TabWDat/TabWe  RAM write port (address row-major y*40+x), all registered
//   busy                 a command is in progress
//   cmd_err              one-cycle pulse when an accepted command is rejected
//
// Build option: define TABW_ANYTIME_EN to ignore blanking and write immediately (tearing accepted).

// Line-counter field of the pixel stream; the pixel-stream layout header may define it first.
`ifndef YC
`define YC 19:10
`endif

module game_table_writer #(
  parameter int TAB_WIDTH   = 40,
  parameter int TAB_HEIGHT  = 30,
  parameter int VISIBLEROWS = 480
) (
  input  logic                      px_clk,
  input  logic                      rst_n,
  input  logic [25:0]               RGBStr_i,
  game_table_writer_if.slave        cmd,
  output logic [10:0]               TabWAdd,
  output logic [3:0]                TabWDat,
  output logic                      TabWe,
  output logic                      busy,
  output logic                      cmd_err
);

  typedef enum logic [1:0] {
    OP_PUT   = 2'd0,
    OP_HLINE = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VB = 2'd1,
    S_WRITE   = 2'd2
  } state_e;

  localparam logic [10:0] TAB_CELLS = 11'(TAB_WIDTH * TAB_HEIGHT);
  localparam logic [5:0]  TAB_W6    = 6'(TAB_WIDTH);
  localparam logic [4:0]  TAB_H5    = 5'(TAB_HEIGHT);

  state_e      state_q, state_d;
  logic        vb_q, vb_d;
  logic [10:0] wadd_q, wadd_d;
  logic [3:0]  wdat_q, wdat_d;
  logic        we_q, we_d;
  logic        err_q, err_d;

  // The latched command is kept in already-decoded form: the tile to write,
  // the next address to write and how many writes remain. That is all the
  // write sequencer needs, and it makes pause/resume trivial.
  logic [3:0]  tile_q, tile_d;
  logic [10:0] next_add_q, next_add_d;
  logic [10:0] remain_q, remain_d;

  // Blanking flag, registered from the pixel stream line counter.
`ifdef TABW_ANYTIME_EN
  assign vb_d = 1'b1;
`else
  logic [9:0] yc;
  assign yc   = RGBStr_i[`YC];
  assign vb_d = (yc >= 10'(VISIBLEROWS));
`endif

  // Decode of the command currently presented on the channel.
  op_e         in_op;
  logic        accept;
  logic        bad_cmd;
  logic [10:0] row_base;
  logic [10:0] start_add;
  logic [5:0]  room;
  logic [5:0]  hl_cnt;

  always_comb begin
    in_op     = op_e'(cmd.cmd_op);
    accept    = cmd.cmd_valid && (state_q == S_IDLE);
    bad_cmd   = (in_op == OP_RSVD) ||
                ((in_op != OP_CLEAR) &&
                 ((cmd.cmd_x >= TAB_W6) || (cmd.cmd_y >= TAB_H5)));
    // y*40 as (y<<5)+(y<<3): no multiplier on the row base.
    row_base  = (11'(cmd.cmd_y) << 5) + (11'(cmd.cmd_y) << 3);
    start_add = row_base + 11'(cmd.cmd_x);
    // Tiles left on the row from x; only meaningful once x is known in range.
    room      = TAB_W6 - cmd.cmd_x;
    hl_cnt    = (cmd.cmd_len < room) ? cmd.cmd_len : room;
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    tile_d     = tile_q;
    next_add_d = next_add_q;
    remain_d   = remain_q;
    wadd_d     = wadd_q;
    wdat_d     = wdat_q;
    we_d       = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bad_cmd) begin
            // Rejected commands are consumed but never leave IDLE.
            err_d = 1'b1;
          end else begin
            state_d = S_WAIT_VB;
            tile_d  = cmd.cmd_tile;
            case (in_op)
              OP_PUT: begin
                next_add_d = start_add;
                remain_d   = 11'd1;
              end
              OP_HLINE: begin
                next_add_d = start_add;
                remain_d   = 11'(hl_cnt);
              end
              default: begin
                next_add_d = '0;
                remain_d   = TAB_CELLS;
              end
            endcase
          end
        end
      end

      S_WAIT_VB: begin
        // A zero-length HLINE arrives here with nothing to do.
        if (remain_q == '0) begin
          state_d = S_IDLE;
        end else if (vb_q) begin
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        // The emptiness test comes first so the cycle after the last write
        // always returns to IDLE, whatever blanking does.
        if (remain_q == '0) begin
          state_d = S_IDLE;
        end else if (!vb_q) begin
          // Visible region started: park, keeping next_add/remain intact.
          state_d = S_WAIT_VB;
        end else begin
          we_d       = 1'b1;
          wadd_d     = next_add_q;
          wdat_d     = tile_q;
          next_add_d = next_add_q + 11'd1;
          remain_d   = remain_q - 11'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      vb_q       <= 1'b0;
      wadd_q     <= '0;
      wdat_q     <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      tile_q     <= '0;
      next_add_q <= '0;
      remain_q   <= '0;
    end else begin
      state_q    <= state_d;
      vb_q       <= vb_d;
      wadd_q     <= wadd_d;
      wdat_q     <= wdat_d;
      we_q       <= we_d;
      err_q      <= err_d;
      tile_q     <= tile_d;
      next_add_q <= next_add_d;
      remain_q   <= remain_d;
    end
  end

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign TabWAdd       = wadd_q;
  assign TabWDat       = wdat_q;
  assign TabWe         = we_q;
  assign cmd_err       = err_q;

endmodule
